// File: rtl/eth_arb_pkg.sv
// Shared types for the Ethernet TX frame arbiter.
// State encoding and counter widths.
package eth_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    ABORT,
    DRAIN
  } arb_state_t;

  localparam int BYTE_W  = 14;
  localparam int STALL_W = 16;

endpackage

// File: rtl/eth_rr_arbiter.sv
// Combinational N-way round-robin pick.
// Searches upward from ptr+1, wrapping.
module eth_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int c;

  // Scan farthest first so the nearest request wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    c   = 0;
    any = |req;
    for (int k = N; k >= 1; k--) begin
      c = (int'(ptr) + k) % N;
      if (req[c]) begin
        gnt    = '0;
        gnt[c] = 1'b1;
        idx    = c[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter for the MAC TX stream.
// Aborts over-length and stalled frames with tuser=1.
module eth_tx_frame_arbiter
  import eth_arb_pkg::*;
#(
  parameter int N_SRC         = 2,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [N_SRC-1:0]         src_mask,
  input  logic [8*N_SRC-1:0]       s_axis_tdata,
  input  logic [N_SRC-1:0]         s_axis_tvalid,
  input  logic [N_SRC-1:0]         s_axis_tlast,
  input  logic [N_SRC-1:0]         s_axis_tuser,
  output logic [N_SRC-1:0]         s_axis_tready,
  output logic [7:0]               m_axis_tdata,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tuser,
  input  logic                     m_axis_tready,
  output logic                     busy,
  output logic [$clog2(N_SRC)-1:0] grant_id,
  output logic                     frame_done,
  output logic                     frame_trunc,
  output logic                     frame_timeout
);

  localparam int IW = $clog2(N_SRC);

  arb_state_t         state;
  logic [IW-1:0]      rr_ptr;
  logic [BYTE_W-1:0]  byte_cnt;
  logic [STALL_W-1:0] stall_cnt;

  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  logic [7:0] g_data;
  logic       g_valid;
  logic       g_last;
  logic       g_user;
  logic       at_max;
  logic       stall_hit;

  assign req = s_axis_tvalid & src_mask & {N_SRC{enable}};

  eth_rr_arbiter #(
    .N  (N_SRC),
    .IW (IW)
  ) u_rr (
    .req (req),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign g_data    = s_axis_tdata[8*int'(grant_id) +: 8];
  assign g_valid   = s_axis_tvalid[grant_id];
  assign g_last    = s_axis_tlast[grant_id];
  assign g_user    = s_axis_tuser[grant_id];
  assign at_max    = byte_cnt == BYTE_W'(MAX_FRAME_LEN - 1);
  assign stall_hit = stall_cnt == STALL_W'(STALL_TIMEOUT - 1);
  assign busy      = state != IDLE;

  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    s_axis_tready = '0;
    unique case (state)
      XFER: begin
        m_axis_tdata  = g_data;
        m_axis_tvalid = g_valid;
        // The MAX-th byte is forced to close the frame as errored.
        m_axis_tlast  = g_last | at_max;
        m_axis_tuser  = g_user | (at_max & ~g_last);
        s_axis_tready[grant_id] = m_axis_tready;
      end
      ABORT: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        m_axis_tuser  = 1'b1;
      end
      DRAIN: s_axis_tready[grant_id] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant_id      <= '0;
      rr_ptr        <= IW'(N_SRC - 1);
      byte_cnt      <= '0;
      stall_cnt     <= '0;
      frame_done    <= 1'b0;
      frame_trunc   <= 1'b0;
      frame_timeout <= 1'b0;
    end else begin
      frame_done    <= 1'b0;
      frame_trunc   <= 1'b0;
      frame_timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            grant_id  <= pick_idx;
            rr_ptr    <= pick_idx;
            byte_cnt  <= '0;
            stall_cnt <= '0;
            state     <= XFER;
          end
        end
        XFER: begin
          if (g_valid) begin
            stall_cnt <= '0;
            if (m_axis_tready) begin
              byte_cnt <= byte_cnt + 1'b1;
              if (g_last) begin
                frame_done <= 1'b1;
                byte_cnt   <= '0;
                state      <= IDLE;
              end else if (at_max) begin
                frame_trunc <= 1'b1;
                byte_cnt    <= '0;
                state       <= DRAIN;
              end
            end
          end else if (stall_hit) begin
            stall_cnt <= '0;
            state     <= ABORT;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        ABORT: begin
          if (m_axis_tready) begin
            frame_timeout <= 1'b1;
            byte_cnt      <= '0;
            state         <= DRAIN;
          end
        end
        DRAIN: begin
          if (g_valid) begin
            stall_cnt <= '0;
            if (g_last) state <= IDLE;
          end else if (stall_hit) begin
            stall_cnt <= '0;
            state     <= IDLE;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Randomized bench for eth_tx_frame_arbiter.
// Expected MAC beats come from a frame-level model.
module tb_eth_tx_frame_arbiter;

  localparam int N_SRC = 2;
  localparam int MAXL  = 1518;
  localparam int STALL = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable;
  logic [1:0]  src_mask;
  logic [15:0] s_tdata;
  logic [1:0]  s_tvalid, s_tlast, s_tuser, s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tlast, m_tuser, m_tready;
  logic        busy;
  logic [0:0]  grant_id;
  logic        frame_done, frame_trunc, frame_timeout;

  always #4 clk = ~clk;

  eth_tx_frame_arbiter #(
    .N_SRC         (N_SRC),
    .MAX_FRAME_LEN (MAXL),
    .STALL_TIMEOUT (STALL)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .src_mask      (src_mask),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tuser  (s_tuser),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser),
    .m_axis_tready (m_tready),
    .busy          (busy),
    .grant_id      (grant_id),
    .frame_done    (frame_done),
    .frame_trunc   (frame_trunc),
    .frame_timeout (frame_timeout)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       user;
    int         gap;
  } beat_t;

  beat_t       sq[2][$];
  logic [31:0] expq[$];
  bit          mon_on = 1'b1;
  bit [1:0]    hs;
  int          errors = 0;
  int          checks = 0;
  int          n_done = 0;
  int          n_trunc = 0;
  int          n_to = 0;
  int          n_beats = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] beat_word(input int src,
      input logic [7:0] d, input logic l, input logic u);
    return {18'd0, 4'(src), d, l, u};
  endfunction

  // Model: normal frames pass as-is, long frames cut at MAXL,
  // stalled frames end in one 0x00 error beat.
  task automatic add_frame(input int src, input int len,
                           input int stall_at, input bit chk_en);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = 8'($urandom);
      b.user = ($urandom_range(0, 7) == 0);
      b.last = (k == len - 1);
      if (k == stall_at) b.gap = STALL + 80;
      else if (k > 0 && $urandom_range(0, 5) == 0)
        b.gap = int'($urandom_range(1, 3));
      else b.gap = 0;
      sq[src].push_back(b);
      if (chk_en) begin
        if (stall_at >= 0) begin
          if (k < stall_at)
            expq.push_back(beat_word(src, b.data, b.last, b.user));
          else if (k == stall_at)
            expq.push_back(beat_word(src, 8'h00, 1'b1, 1'b1));
        end else if (len > MAXL) begin
          if (k < MAXL - 1)
            expq.push_back(beat_word(src, b.data, b.last, b.user));
          else if (k == MAXL - 1)
            expq.push_back(beat_word(src, b.data, 1'b1, 1'b1));
        end else begin
          expq.push_back(beat_word(src, b.data, b.last, b.user));
        end
      end
    end
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k;
    k = 0;
    while (!(sq[0].size() == 0 && sq[1].size() == 0 &&
             expq.size() == 0 && !busy) && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check(tag, 32'(k < budget), 32'd1);
  endtask

  // Per-cycle engine: sample at negedge, drive after posedge.
  initial begin : engine
    logic [31:0] w;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) hs[i] = s_tvalid[i] & s_tready[i];
      n_done  += int'(frame_done);
      n_trunc += int'(frame_trunc);
      n_to    += int'(frame_timeout);
      if (rst_n && m_tvalid && m_tready) begin
        n_beats++;
        if (mon_on) begin
          w = beat_word(int'(grant_id), m_tdata, m_tlast, m_tuser);
          if (expq.size() == 0) check("extra_beat", w, 32'hffffffff);
          else check("mac_beat", w, expq.pop_front());
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (hs[i] && sq[i].size() > 0) void'(sq[i].pop_front());
        s_tvalid[i] = 1'b0;
        if (sq[i].size() > 0) begin
          if (sq[i][0].gap > 0) begin
            sq[i][0].gap = sq[i][0].gap - 1;
          end else begin
            s_tvalid[i]        = 1'b1;
            s_tdata[8*i +: 8]  = sq[i][0].data;
            s_tlast[i]         = sq[i][0].last;
            s_tuser[i]         = sq[i][0].user;
          end
        end
      end
      m_tready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : guard
    #(60000 * 8);
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin : main
    int d0, t0, o0, b0, k;
    bit hit;
    enable   = 1'b1;
    src_mask = 2'b11;
    s_tdata  = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tuser  = '0;
    m_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs",
          32'({m_tvalid, m_tlast, m_tuser, m_tdata, s_tready, busy,
               grant_id, frame_done, frame_trunc, frame_timeout}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Alternating grants, incl. single-byte and 64-byte frames.
    d0 = n_done;
    add_frame(0, 64, -1, 1'b1);
    add_frame(1, 1, -1, 1'b1);
    add_frame(0, int'($urandom_range(2, 64)), -1, 1'b1);
    add_frame(1, 64, -1, 1'b1);
    add_frame(0, int'($urandom_range(2, 64)), -1, 1'b1);
    add_frame(1, int'($urandom_range(2, 64)), -1, 1'b1);
    wait_done(5000, "alt_drain");
    check("alt_done_cnt", 32'(n_done - d0), 32'd6);

    // Masked source is not granted until unmasked.
    @(posedge clk);
    #2;
    src_mask = 2'b01;
    add_frame(1, 8, -1, 1'b1);
    repeat (20) @(negedge clk);
    check("mask_no_grant", 32'(busy), 32'd0);
    @(posedge clk);
    #2;
    src_mask = 2'b11;
    hit = 1'b0;
    for (int i = 0; i < 2 && !hit; i++) begin
      @(negedge clk);
      if (busy && grant_id == 1'b1) hit = 1'b1;
    end
    check("mask_grant_s1", 32'(hit), 32'd1);
    wait_done(2000, "mask_drain");

    // Over-length, then normal, then exactly MAXL bytes.
    @(posedge clk);
    #2;
    d0 = n_done;
    t0 = n_trunc;
    add_frame(0, 1600, -1, 1'b1);
    add_frame(0, 20, -1, 1'b1);
    add_frame(0, MAXL, -1, 1'b1);
    wait_done(20000, "trunc_drain");
    check("trunc_pulse", 32'(n_trunc - t0), 32'd1);
    check("trunc_done_cnt", 32'(n_done - d0), 32'd2);

    // Mid-frame stall after 10 bytes.
    @(posedge clk);
    #2;
    o0 = n_to;
    d0 = n_done;
    add_frame(1, 15, 10, 1'b1);
    wait_done(5000, "stall_drain");
    check("timeout_pulse", 32'(n_to - o0), 32'd1);
    check("timeout_no_done", 32'(n_done - d0), 32'd0);

    // Reset in the middle of a frame.
    @(posedge clk);
    #2;
    mon_on   = 1'b0;
    src_mask = 2'b10;
    b0 = n_beats;
    add_frame(1, 60, -1, 1'b0);
    k = 0;
    while (n_beats - b0 < 20 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("rst_mid_progress", 32'(k < 2000), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs",
          32'({m_tvalid, m_tlast, m_tuser, m_tdata, s_tready, busy,
               grant_id, frame_done, frame_trunc, frame_timeout}), 32'd0);
    sq[0].delete();
    sq[1].delete();
    mon_on   = 1'b1;
    src_mask = 2'b11;
    d0 = n_done;
    add_frame(0, 5, -1, 1'b1);
    add_frame(1, 5, -1, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_done(2000, "post_rst_drain");
    check("post_rst_done_cnt", 32'(n_done - d0), 32'd2);
    check("exp_empty", 32'(expq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_tx_frame_arbiter.md
# eth_tx_frame_arbiter

Frame-granular round-robin arbiter sharing the single 8-bit AXI-stream TX port of the 1G RGMII MAC between N_SRC requesters (uDMA TX channel, loopback/test generator, etc.). Grants are held for a whole frame (to tlast), so frames are never interleaved. It also enforces a maximum frame length and a mid-frame stall timeout, aborting bad frames towards the MAC with tuser=1 so the MAC FIFO drops them. It sits between the uDMA Ethernet channel logic and the MAC TX FIFO, in the 125 MHz logic clock domain.

## Interface
- N_SRC, 2, number of requesters (2..8)
- MAX_FRAME_LEN, 1518, byte limit per frame, excluding FCS (64..16383)
- STALL_TIMEOUT, 1024, idle cycles mid-frame before abort (2..65535)
- clk  in  1  logic clock, 125 MHz
- rst_n  in  1  asynchronous reset, active low
- enable  in  1  allow new grants; a frame in progress always completes
- src_mask  in  N_SRC  per-source grant enable; sampled only in IDLE
- s_axis_tdata  in  8*N_SRC  source data, source i at [8i+7:8i]
- s_axis_tvalid / s_axis_tlast / s_axis_tuser  in  N_SRC each  per-source stream controls
- s_axis_tready  out  N_SRC  per-source ready
- m_axis_tdata  out  8  to MAC tx_axis_tdata
- m_axis_tvalid / m_axis_tlast / m_axis_tuser  out  1 each  to MAC
- m_axis_tready  in  1  from MAC
- busy  out  1  state != IDLE
- grant_id  out  $clog2(N_SRC)  current/last granted source
- frame_done  out  1  one-cycle pulse: frame ended normally (tlast passed)
- frame_trunc  out  1  one-cycle pulse: length abort
- frame_timeout  out  1  one-cycle pulse: stall abort

## Operation
- Reset: state IDLE, grant_id 0, rr pointer = N_SRC-1 (source 0 wins first), counters 0; all outputs 0.
- IDLE: req = s_axis_tvalid & src_mask & {N_SRC{enable}}. If req != 0, pick first set bit searching upward from rr pointer+1 (wrapping); register grant_id, set rr pointer = grant, go XFER. s_axis_tready all 0.
- XFER: m_axis_tdata/tvalid/tlast/tuser = granted source (combinational mux); s_axis_tready[grant] = m_axis_tready, others 0. Byte counter increments per accepted beat.
  - Accepted beat with tlast: pulse frame_done, clear counters, go IDLE.
  - Accepted beat without tlast when byte count == MAX_FRAME_LEN-1: drive m_axis_tlast=1, m_axis_tuser=1 on that beat; pulse frame_trunc; go DRAIN.
  - Stall counter counts cycles with granted tvalid low, clears on any granted tvalid high. At STALL_TIMEOUT go ABORT.
- ABORT: m_axis_tvalid=1, tdata=0x00, tlast=1, tuser=1; s_axis_tready 0. On m_axis_tready: pulse frame_timeout, go DRAIN.
- DRAIN: m_axis_tvalid=0; s_axis_tready[grant]=1, discarding beats until accepted tlast -> IDLE. Stall counter also runs; at STALL_TIMEOUT -> IDLE (source abandoned).
- Source tuser passes through unchanged in XFER; the arbiter does not interpret it.
- Counters: byte 14 bits, stall 16 bits, saturating never needed (bounded by state exits).

## Timing
- One bubble cycle per frame for arbitration (IDLE -> XFER); back-to-back frames from one source: one idle cycle between tlast and next first beat.
- Zero-latency data path in XFER; no registering of tdata (MAC FIFO provides the register stage).
- enable low or src_mask change mid-frame: no effect until IDLE.
- Single-byte frame (tlast on first beat): legal, frame_done.
- tlast on exactly the MAX_FRAME_LEN-th byte: normal completion, no truncation.
- rst_n assertion mid-frame: immediate return to IDLE, outputs 0; MAC sees an unterminated frame and is reset together.

## Structure
- Package eth_arb_pkg: state enum (IDLE, XFER, ABORT, DRAIN), byte/stall counter width constants.
- Sub-module eth_rr_arbiter: combinational N-way round-robin pick (req, pointer -> one-hot grant + index).

## Test plan
- Both sources valid continuously, 64-byte frames -> grants alternate 0,1,0,1; each frame_done pulses once; data byte-exact.
- Source 1 only, src_mask=2'b01 -> no grant; mask 2'b11 -> source 1 granted within 2 cycles.
- 1600-byte frame, MAX_FRAME_LEN=1518 -> 1518 bytes to MAC, last with tlast=1,tuser=1; frame_trunc; remaining 82 bytes drained; next frame normal.
- Source drops tvalid after 10 bytes for 1024 cycles -> one dummy beat 0x00 tlast=1 tuser=1; frame_timeout; late bytes drained to tlast.
- m_axis_tready toggled randomly -> no beat lost or duplicated; ABORT beat held until ready.
- rst_n pulse mid-frame -> all outputs 0 next cycle; after release source 0 wins first.
